// File: rtl/barrel_pkg.sv
// Shared types and constants for the shared-shifter scheduler.
package barrel_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    // Bit 1 set = rotate, bit 0 set = right-going first pass.
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC1 = 2'b01,
        EXEC2 = 2'b10,
        RESP  = 2'b11
    } state_e;

    // A rotate by a non-zero amount needs the second (complementary) pass.
    function automatic logic needs_second_pass(input op_e op, input logic [AMT_W-1:0] amt);
        return op[1] && (amt != '0);
    endfunction

endpackage

// File: rtl/barrel_shift_sched_if.sv
// Request/response bundle between client blocks and the scheduler.
//
// Handshake: every channel uses valid/ready. A transfer happens on a rising
// clk edge where valid && ready are both 1. The producer holds valid and its
// payload stable until that edge; it may drop valid before ready, in which
// case nothing transfers. ready may depend combinationally on valid.
interface barrel_shift_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ*5-1:0]  req_amt;
    logic [NUM_REQ*2-1:0]  req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;

    // Client side.
    modport master (
        output req_valid, req_data, req_amt, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_data, req_amt, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/barrel_shift_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap and
// returns a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // First set bit after ptr wins; ptr itself is checked last.
    always_comb begin
        int cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/barrel_shifter_32b.sv
// Combinational 32-bit logical shifter: lr=0 shifts left, lr=1 shifts right,
// vacated bits are zero-filled.
module barrel_shifter_32b (
    input  logic [31:0] in,
    input  logic [4:0]  shft_amt,
    input  logic        lr,
    output logic [31:0] out
);

    // Five log2 stages, each conditionally shifting by a power of two.
    always_comb begin
        out = in;
        for (int s = 0; s < 5; s++) begin
            if (shft_amt[s]) begin
                out = lr ? (out >> (1 << s)) : (out << (1 << s));
            end
        end
    end

endmodule

// File: rtl/barrel_shift_sched.sv
// Shares one barrel_shifter_32b among NUM_REQ requesters with round-robin
// arbitration. Rotates are built from two opposite-direction shifts ORed.
module barrel_shift_sched
    import barrel_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    barrel_shift_sched_if.slave  bus,
    output logic                 busy,
    output state_e               state_dbg
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_e              state, state_nx;
    logic [ID_W-1:0]     ptr;
    logic [DATA_W-1:0]   op_data;
    logic [AMT_W-1:0]    op_amt;
    op_e                 op_op;
    logic [ID_W-1:0]     op_id;
    logic [DATA_W-1:0]   acc;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     win_idx;
    logic                win_any;

    logic [AMT_W-1:0]    sh_amt;
    logic                sh_lr;
    logic [DATA_W-1:0]   sh_out;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    barrel_shifter_32b u_shifter (
        .in       (op_data),
        .shft_amt (sh_amt),
        .lr       (sh_lr),
        .out      (sh_out)
    );

    // Second rotate pass shifts the other way by the complementary amount.
    always_comb begin
        sh_amt = op_amt;
        sh_lr  = op_op[0];
        if (state == EXEC2) begin
            sh_amt = AMT_W'(DATA_W - int'(op_amt));
            sh_lr  = ~op_op[0];
        end
    end

    // State register, operand capture, pointer update and result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= ID_W'(NUM_REQ - 1);
            op_data <= '0;
            op_amt  <= '0;
            op_op   <= OP_SLL;
            op_id   <= '0;
            acc     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        op_data <= bus.req_data[win_idx*DATA_W +: DATA_W];
                        op_amt  <= bus.req_amt[win_idx*AMT_W +: AMT_W];
                        op_op   <= op_e'(bus.req_op[win_idx*2 +: 2]);
                        op_id   <= win_idx;
                        ptr     <= win_idx;
                    end
                end
                EXEC1:   acc <= sh_out;
                EXEC2:   acc <= acc | sh_out;
                default: ;
            endcase
        end
    end

    // Next-state logic: one operation in flight, response held until taken.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (win_any) state_nx = EXEC1;
            EXEC1: state_nx = needs_second_pass(op_op, op_amt) ? EXEC2 : RESP;
            EXEC2: state_nx = RESP;
            RESP:  if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // req_ready is forced low while reset is asserted so no grant leaks out.
    assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = acc;
    assign bus.rsp_id    = op_id;
    assign busy          = (state != IDLE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_barrel_shift_sched.sv
// Directed bench for barrel_shift_sched: inputs driven and outputs sampled
// around the falling clock edge.
module tb_barrel_shift_sched;
    import barrel_pkg::*;

    localparam int NUM_REQ = 4;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   busy;
    state_e state_dbg;

    always #5 clk = ~clk;

    barrel_shift_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    barrel_shift_sched #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] a, input op_e op);
        bus.req_data[32*i +: 32] = d;
        bus.req_amt[5*i +: 5]    = a;
        bus.req_op[2*i +: 2]     = op;
        bus.req_valid[i]         = 1'b1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for rsp_valid; returns cycles counted from the accept cycle.
    task automatic wait_rsp(output int n);
        n = 1;
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One request from requester i, served alone, with full latency/data/id checks.
    task automatic run_op(input string tag, input int i, input logic [31:0] d,
                          input logic [4:0] a, input op_e op,
                          input logic [31:0] exp, input int lat);
        int n;
        set_req(i, d, a, op);
        exp_q.push_back(exp);
        #1;
        check($sformatf("%s grant", tag), 32'(bus.req_ready), 32'd1 << i);
        @(negedge clk);
        bus.req_valid[i] = 1'b0;
        wait_rsp(n);
        check($sformatf("%s latency", tag), 32'(n), 32'(lat));
        check($sformatf("%s data", tag), bus.rsp_data, exp_q.pop_front());
        check($sformatf("%s id", tag), 32'(bus.rsp_id), 32'(i));
        @(negedge clk);
        check($sformatf("%s rsp_valid drop", tag), 32'(bus.rsp_valid), 32'd0);
    endtask

    // With several requesters held valid, expect the next grant to go to exp_idx.
    task automatic serve(input string tag, input int exp_idx);
        int n;
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("%s grant", tag), 32'(bus.req_ready), 32'd1 << exp_idx);
        @(negedge clk);
        wait_rsp(n);
        check($sformatf("%s id", tag), 32'(bus.rsp_id), 32'(exp_idx));
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_amt   = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;

        // Reset values.
        #2;
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst rsp_data", bus.rsp_data, 32'd0);
        check("rst rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst req_ready", 32'(bus.req_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        do_reset();

        // Single shifts and rotates by 5.
        run_op("sll5", 0, 32'h12345678, 5'd5, OP_SLL, 32'h468ACF00, 2);
        run_op("srl5", 1, 32'h12345678, 5'd5, OP_SRL, 32'h0091A2B3, 2);
        run_op("rol5", 1, 32'h12345678, 5'd5, OP_ROL, 32'h468ACF02, 3);
        run_op("ror5", 1, 32'h12345678, 5'd5, OP_ROR, 32'hC091A2B3, 3);

        // Round-robin from reset: all four held valid.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h1 << i, 5'd1, OP_SLL);
        for (int k = 0; k < NUM_REQ; k++) serve($sformatf("rr4_%0d", k), k);
        bus.req_valid = 4'b0101;
        serve("rr2_0", 0);
        serve("rr2_1", 2);
        serve("rr2_2", 0);
        serve("rr2_3", 2);
        bus.req_valid = '0;
        @(negedge clk);

        // Response back-pressure: everything must hold while rsp_ready is low.
        bus.rsp_ready = 1'b0;
        set_req(1, 32'hA5A5A5A5, 5'd4, OP_SLL);
        #1;
        check("stall grant", 32'(bus.req_ready), 32'd2);
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(n);
        set_req(0, 32'h0, 5'd0, OP_SLL);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("stall%0d rsp_data", k), bus.rsp_data, 32'h5A5A5A50);
            check($sformatf("stall%0d rsp_id", k), 32'(bus.rsp_id), 32'd1);
            check($sformatf("stall%0d req_ready", k), 32'(bus.req_ready), 32'd0);
            check($sformatf("stall%0d busy", k), 32'(busy), 32'd1);
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("stall release", 32'(bus.rsp_valid), 32'd0);

        // Zero-amount rotates skip the second pass; amount 31 boundary.
        run_op("rol0", 2, 32'hDEADBEEF, 5'd0, OP_ROL, 32'hDEADBEEF, 2);
        run_op("ror0", 3, 32'hDEADBEEF, 5'd0, OP_ROR, 32'hDEADBEEF, 2);
        run_op("rol31", 0, 32'h00000001, 5'd31, OP_ROL, 32'h80000000, 3);

        // Reset during EXEC2 discards the op and restores the pointer.
        set_req(0, 32'h0F0F0000, 5'd8, OP_ROL);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        check("mid state EXEC2", 32'(state_dbg), 32'(EXEC2));
        bus.req_valid = 4'b0011;
        rst_n = 1'b0;
        #1;
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid rst rsp_data", bus.rsp_data, 32'd0);
        check("mid rst rsp_id", 32'(bus.rsp_id), 32'd0);
        check("mid rst req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post rst ptr", 32'(bus.req_ready), 32'd1);
        bus.req_valid = '0;
        @(negedge clk);
        run_op("post rst req3", 3, 32'h0000000F, 5'd4, OP_ROR, 32'hF0000000, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
